// File: rtl/updn_mod_cntr.sv
// N-bit up/down counter with programmable modulus, synchronous load, enable-gated
// prescaler, wrap/saturate boundary handling, terminal-count pulse and sticky flags.
module updn_mod_cntr #(
  parameter int N        = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         up,
  input  logic [N-1:0] mod_max,
  input  logic         clr_flags,
  output logic [N-1:0] Q,
  output logic         tc,
  output logic         ovf,
  output logic         unf
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
  localparam bit SAT = (SATURATE != 0);

  logic [N-1:0]  q_q, q_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic          tc_q, tc_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          tick;
  logic          ovf_set, unf_set;

  generate
    if (PRESCALE == 1) begin : g_tick_direct
      assign tick = en;
    end else begin : g_tick_pre
      assign tick = en && (pcnt_q == PMAX);
    end
  endgenerate

  always_comb begin
    q_d     = q_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (load) begin
      q_d    = (load_val <= mod_max) ? load_val : mod_max;
      pcnt_d = '0;
    end else begin
      // pcnt holds its phase while en is low
      if (en) pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      if (tick) begin
        if (up) begin
          // boundary check before increment: q_q+1 cannot wrap through 2^N
          if (q_q < mod_max) begin
            q_d = q_q + 1'b1;
          end else begin
            tc_d    = 1'b1;
            ovf_set = 1'b1;
            q_d     = SAT ? mod_max : '0;
          end
        end else if (q_q > mod_max) begin
          q_d = mod_max;
        end else if (q_q != '0) begin
          q_d = q_q - 1'b1;
        end else begin
          tc_d    = 1'b1;
          unf_set = 1'b1;
          q_d     = SAT ? '0 : mod_max;
        end
      end
    end
    // a coincident set beats the clear
    ovf_d = ovf_set | (ovf_q & ~clr_flags);
    unf_d = unf_set | (unf_q & ~clr_flags);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q    <= '0;
      pcnt_q <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      pcnt_q <= pcnt_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
    end
  end

  assign Q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_updn_mod_cntr.sv
// Directed bench for updn_mod_cntr: three builds (wrap, prescale-3, saturate) share
// stimulus; expected post-edge states are queued and checked after each edge.
module tb_updn_mod_cntr;

  logic       clk = 1'b0;
  logic       rst, en, load, up, clr;
  logic [7:0] load_val, mod_max;
  logic [7:0] qv   [3];
  logic       tcv  [3];
  logic       ovfv [3];
  logic       unfv [3];

  always #5 clk = ~clk;

  updn_mod_cntr #(.N(8), .PRESCALE(1), .SATURATE(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .up(up),
    .mod_max(mod_max), .clr_flags(clr), .Q(qv[0]), .tc(tcv[0]), .ovf(ovfv[0]), .unf(unfv[0]));
  updn_mod_cntr #(.N(8), .PRESCALE(3), .SATURATE(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .up(up),
    .mod_max(mod_max), .clr_flags(clr), .Q(qv[1]), .tc(tcv[1]), .ovf(ovfv[1]), .unf(unfv[1]));
  updn_mod_cntr #(.N(8), .PRESCALE(1), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val), .up(up),
    .mod_max(mod_max), .clr_flags(clr), .Q(qv[2]), .tc(tcv[2]), .ovf(ovfv[2]), .unf(unfv[2]));

  typedef struct {
    string      tag;
    int         d;
    logic [7:0] q;
    logic       tc, ovf, unf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic exp(input string tag, input int d, input int q,
                     input bit t, input bit o, input bit u);
    exp_t e;
    e.tag = tag; e.d = d; e.q = q[7:0]; e.tc = t; e.ovf = o; e.unf = u;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [10:0] obs, req;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = {qv[e.d], tcv[e.d], ovfv[e.d], unfv[e.d]};
      req = {e.q, e.tc, e.ovf, e.unf};
      checks++;
      assert (obs === req) else begin
        errors++;
        $error("FAIL %s dut%0d observed q=%0d tc=%b ovf=%b unf=%b expected q=%0d tc=%b ovf=%b unf=%b",
               e.tag, e.d, qv[e.d], tcv[e.d], ovfv[e.d], unfv[e.d], e.q, e.tc, e.ovf, e.unf);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; load = 1'b0; clr = 1'b0; up = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    int pq [9];
    int aq [3], at [3], au [3];
    int cq [3], ct [3], cu [3];
    pq = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
    aq = '{0, 4, 3}; at = '{0, 1, 0}; au = '{0, 1, 1};
    cq = '{0, 0, 0}; ct = '{0, 1, 1}; cu = '{0, 1, 1};

    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 8'd0; up = 1'b1; mod_max = 8'd9; clr = 1'b0;
    #2;
    for (int d = 0; d < 3; d++) exp("rst_init", d, 0, 0, 0, 0);
    drain();
    @(posedge clk); #1;
    rst = 1'b0;

    // count to 5, then async reset mid-cycle
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin exp("cnt_pre", 0, i, 0, 0, 0); cyc(); end
    #3 rst = 1'b1;
    #1 exp("rst_async", 0, 0, 0, 0, 0);
    drain();
    exp("rst_hold", 0, 0, 0, 0, 0); cyc();
    rst = 1'b0;
    for (int i = 1; i <= 9; i++) begin exp("cnt_up", 0, i, 0, 0, 0); cyc(); end
    exp("cnt_wrap", 0, 0, 1, 1, 0); cyc();
    exp("cnt_after", 0, 1, 0, 1, 0); cyc();

    // prescaler, with en dropout preserving phase
    do_reset();
    mod_max = 8'd9; up = 1'b1; en = 1'b1;
    for (int i = 0; i < 9; i++) begin exp("pre_step", 1, pq[i], 0, 0, 0); cyc(); end
    exp("pre_en1", 1, 3, 0, 0, 0); cyc();
    exp("pre_en2", 1, 3, 0, 0, 0); cyc();
    en = 1'b0;
    exp("pre_off1", 1, 3, 0, 0, 0); cyc();
    exp("pre_off2", 1, 3, 0, 0, 0); cyc();
    en = 1'b1;
    exp("pre_resume", 1, 4, 0, 0, 0); cyc();

    // down count / underflow, wrap and saturate builds together
    do_reset();
    mod_max = 8'd4; load_val = 8'd1; load = 1'b1; en = 1'b1;
    exp("dn_load", 0, 1, 0, 0, 0); exp("dn_load", 2, 1, 0, 0, 0); cyc();
    load = 1'b0; up = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp("dn_wrap", 0, aq[i], at[i][0], 0, au[i][0]);
      exp("dn_sat", 2, cq[i], ct[i][0], 0, cu[i][0]);
      cyc();
    end

    // load clamp; load clears prescaler phase
    do_reset();
    mod_max = 8'd10; up = 1'b1; en = 1'b1;
    exp("clamp_pre", 0, 1, 0, 0, 0); exp("clamp_pre", 1, 0, 0, 0, 0); cyc();
    load_val = 8'd200; load = 1'b1;
    exp("clamp_ld", 0, 10, 0, 0, 0); exp("clamp_ld", 1, 10, 0, 0, 0); cyc();
    load = 1'b0;
    exp("clamp_ovf", 0, 0, 1, 1, 0); exp("clamp_p1", 1, 10, 0, 0, 0); cyc();
    exp("clamp_nx", 0, 1, 0, 1, 0); exp("clamp_p2", 1, 10, 0, 0, 0); cyc();
    exp("clamp_nx2", 0, 2, 0, 1, 0); exp("clamp_povf", 1, 0, 1, 1, 0); cyc();

    // runtime mod_max decrease, up tick
    do_reset();
    mod_max = 8'd9; load_val = 8'd8; load = 1'b1;
    exp("mdec_ld", 0, 8, 0, 0, 0); exp("mdec_ld", 2, 8, 0, 0, 0); cyc();
    load = 1'b0; mod_max = 8'd5; up = 1'b1; en = 1'b1;
    exp("mdec_up", 0, 0, 1, 1, 0); exp("mdec_up_sat", 2, 5, 1, 1, 0); cyc();

    // runtime mod_max decrease, down tick
    do_reset();
    mod_max = 8'd9; load_val = 8'd8; load = 1'b1;
    exp("mdec_ld2", 0, 8, 0, 0, 0); exp("mdec_ld2", 2, 8, 0, 0, 0); cyc();
    load = 1'b0; mod_max = 8'd5; up = 1'b0; en = 1'b1;
    exp("mdec_dn", 0, 5, 0, 0, 0); exp("mdec_dn", 2, 5, 0, 0, 0); cyc();
    exp("mdec_dn2", 0, 4, 0, 0, 0); exp("mdec_dn2", 2, 4, 0, 0, 0); cyc();

    // flag clear and set/clear race
    do_reset();
    mod_max = 8'd2; load_val = 8'd2; load = 1'b1;
    exp("clr_ld", 0, 2, 0, 0, 0); cyc();
    load = 1'b0; en = 1'b1; up = 1'b1;
    exp("clr_ovf", 0, 0, 1, 1, 0); cyc();
    en = 1'b0; clr = 1'b1;
    exp("clr_alone", 0, 0, 0, 0, 0); cyc();
    clr = 1'b0; load = 1'b1;
    exp("clr_ld2", 0, 2, 0, 0, 0); cyc();
    load = 1'b0; en = 1'b1; clr = 1'b1;
    exp("clr_race", 0, 0, 1, 1, 0); cyc();
    en = 1'b0;
    exp("clr_again", 0, 0, 0, 0, 0); cyc();
    clr = 1'b0;

    // mod_max = 0: every tick is a boundary, tc back-to-back
    do_reset();
    mod_max = 8'd0; en = 1'b1; up = 1'b1;
    exp("m0_up1", 0, 0, 1, 1, 0); exp("m0_up1", 2, 0, 1, 1, 0); cyc();
    exp("m0_up2", 0, 0, 1, 1, 0); exp("m0_up2", 2, 0, 1, 1, 0); cyc();
    up = 1'b0;
    exp("m0_dn", 0, 0, 1, 1, 1); exp("m0_dn", 2, 0, 1, 1, 1); cyc();
    en = 1'b0;
    exp("m0_idle", 0, 0, 0, 1, 1); exp("m0_idle", 2, 0, 0, 1, 1); cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
